// File: rtl/hyperram_req_scheduler.sv
// hyperram_req_scheduler: in-order Avalon-MM command queue issuing single-cycle pulses to the HyperRAM controller
module hyperram_req_scheduler #(
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 1023,
    parameter int WR_GAP     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] h_address,
    input  logic        h_read,
    input  logic        h_write,
    input  logic [31:0] h_writedata,
    output logic        h_waitrequest,
    output logic [31:0] h_readdata,
    output logic        h_readdatavalid,
    output logic        h_rderror,
    output logic [21:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (RD_TIMEOUT > WR_GAP) ? RD_TIMEOUT : WR_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP} state_t;

    state_t        r_state, w_next;
    logic [54:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_timer;
    logic          r_op;
    logic [54:0]   w_head;
    logic          w_full, w_empty, w_push, w_pop, w_load, w_rd_ok, w_rd_to;

    assign w_full        = r_count == (AW+1)'(DEPTH);
    assign w_empty       = r_count == '0;
    assign h_waitrequest = rst | w_full;
    assign w_push        = (h_read | h_write) & ~h_waitrequest;
    assign w_head        = r_fifo[r_rd_ptr];

    // Command storage; a simultaneous read+write request is stored as a write
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {h_write, h_address, h_writedata};
    end

    // Queue pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Sequencer: one transaction in flight, pop only when it has completed
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_pop   = 1'b0;
        w_rd_ok = 1'b0;
        w_rd_to = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = ~w_empty;
                w_next = w_empty ? IDLE : ISSUE;
            end
            ISSUE:   w_next = r_op ? WAIT_WR : WAIT_RD;
            WAIT_RD: begin
                w_rd_ok = m_readdatavalid;
                w_rd_to = ~m_readdatavalid & (r_timer == '0);
                w_pop   = w_rd_ok | w_rd_to;
                w_next  = w_pop ? GAP : WAIT_RD;
            end
            WAIT_WR: begin
                w_pop  = r_timer == '0;
                w_next = w_pop ? GAP : WAIT_WR;
            end
            GAP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Controller-side and host-side registered outputs plus the wait timer
    always_ff @(posedge clk) begin
        if (rst) begin
            m_read          <= 1'b0;
            m_write         <= 1'b0;
            m_address       <= '0;
            m_writedata     <= '0;
            r_op            <= 1'b0;
            r_timer         <= '0;
            h_readdata      <= '0;
            h_readdatavalid <= 1'b0;
            h_rderror       <= 1'b0;
        end else begin
            m_read          <= w_load & ~w_head[54];
            m_write         <= w_load & w_head[54];
            if (w_load) begin
                r_op        <= w_head[54];
                m_address   <= w_head[53:32];
                m_writedata <= w_head[31:0];
            end
            r_timer         <= (r_state == ISSUE) ? (r_op ? TW'(WR_GAP) : TW'(RD_TIMEOUT))
                                                  : ((r_timer != '0) ? r_timer - TW'(1) : r_timer);
            if (w_rd_ok | w_rd_to) h_readdata <= w_rd_ok ? m_readdata : 32'hDEAD_BEEF;
            h_readdatavalid <= w_rd_ok | w_rd_to;
            h_rderror       <= w_rd_to;
        end
    end
endmodule

// File: tb/tb_hyperram_req_scheduler.sv
// tb_hyperram_req_scheduler: scenario and randomized checks of the HyperRAM request scheduler
module tb_hyperram_req_scheduler;
    localparam int DEPTH  = 4;
    localparam int RD_TO  = 15;
    localparam int WR_GAP = 8;

    typedef struct packed {
        logic        wr;
        logic [21:0] a;
        logic [31:0] d;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] h_address = '0;
    logic        h_read = 1'b0;
    logic        h_write = 1'b0;
    logic [31:0] h_writedata = '0;
    logic        h_waitrequest;
    logic [31:0] h_readdata;
    logic        h_readdatavalid;
    logic        h_rderror;
    logic [21:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_readdatavalid = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int resp_delay = 4;
    bit spur = 1'b0;
    int rd_cnt = 0;
    logic [21:0] rd_addr = '0;
    logic [31:0] ctl_mem [logic [21:0]];

    always #5 clk = ~clk;

    hyperram_req_scheduler #(.DEPTH(DEPTH), .RD_TIMEOUT(RD_TO), .WR_GAP(WR_GAP)) dut (
        .clk(clk), .rst(rst),
        .h_address(h_address), .h_read(h_read), .h_write(h_write), .h_writedata(h_writedata),
        .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
        .h_readdatavalid(h_readdatavalid), .h_rderror(h_rderror),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
    );

    // Controller model: memory, read answered resp_delay cycles after the pulse (0 = never)
    always @(negedge clk) begin
        m_readdatavalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                m_readdatavalid = 1'b1;
                m_readdata = ctl_mem.exists(rd_addr) ? ctl_mem[rd_addr] : 32'h0;
            end
        end
        if (spur) begin
            m_readdatavalid = 1'b1;
            m_readdata = 32'h5555_AAAA;
            spur = 1'b0;
        end
        if (m_read) begin
            rd_addr = m_address;
            rd_cnt = resp_delay;
        end
        if (m_write) ctl_mem[m_address] = m_writedata;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({m_read, m_write, h_readdatavalid, h_rderror} !== 4'b0 || m_address !== '0 || m_writedata !== '0 || h_readdata !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got rd=%b wr=%b rdv=%b err=%b addr=%h wd=%h rdata=%h expected all 0",
                     m_read, m_write, h_readdatavalid, h_rderror, m_address, m_writedata, h_readdata);
        end
        n_vec++;
        if (h_waitrequest !== 1'b1) begin
            n_err++;
            $display("FAIL reset_waitrequest got %b expected 1", h_waitrequest);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (h_waitrequest !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_waitrequest got %b expected 0", h_waitrequest);
        end
    endtask

    task automatic test_single_read();
        ctl_mem[22'h10] = 32'h1234_5678;
        resp_delay = 4;
        h_address = 22'h10;
        h_read = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) h_read = 1'b0;
            n_vec++;
            if (m_read !== 1'(k == 2) || m_write !== 1'b0) begin
                n_err++;
                $display("FAIL single_read_pulse k=%0d got rd=%b wr=%b expected rd=%b wr=0", k, m_read, m_write, k == 2);
            end
            if (k == 2) begin
                n_vec++;
                if (m_address !== 22'h10) begin
                    n_err++;
                    $display("FAIL single_read_addr got %h expected 000010", m_address);
                end
            end
            n_vec++;
            if (h_readdatavalid !== 1'(k == 7)) begin
                n_err++;
                $display("FAIL single_read_rdv k=%0d got %b expected %b", k, h_readdatavalid, k == 7);
            end
            if (k == 7) begin
                n_vec++;
                if (h_readdata !== 32'h1234_5678 || h_rderror !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_read_data got %h err=%b expected 12345678 err=0", h_readdata, h_rderror);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [5];
        int idx = 0;
        int np = 0;
        bit acc = 1'b0;
        for (int i = 0; i < 5; i++) wd[i] = $urandom;
        for (int k = 0; k < 5 * (WR_GAP + 4) + 8; k++) begin
            if (k <= WR_GAP + 4) begin
                n_vec++;
                if (h_waitrequest !== 1'(k >= 4 && k <= WR_GAP + 3)) begin
                    n_err++;
                    $display("FAIL b2b_waitrequest k=%0d got %b expected %b", k, h_waitrequest, k >= 4 && k <= WR_GAP + 3);
                end
            end
            if (m_write || m_read) begin
                n_vec++;
                if (np >= 5 || m_read || k != 2 + (WR_GAP + 4) * np || m_address !== 22'(256 + np) || m_writedata !== wd[np]) begin
                    n_err++;
                    $display("FAIL b2b_pulse k=%0d n=%0d got rd=%b addr=%h wd=%h expected write at k=%0d", k, np, m_read, m_address, m_writedata, 2 + (WR_GAP + 4) * np);
                end
                np++;
            end else if (np > 0) begin
                n_vec++;
                if (m_writedata !== wd[np-1] || m_address !== 22'(256 + np - 1)) begin
                    n_err++;
                    $display("FAIL b2b_stable k=%0d got addr=%h wd=%h expected addr=%h wd=%h", k, m_address, m_writedata, 22'(256 + np - 1), wd[np-1]);
                end
            end
            if (acc) begin idx++; h_write = 1'b0; end
            if (idx < 5) begin h_write = 1'b1; h_address = 22'(256 + idx); h_writedata = wd[idx]; end
            acc = h_write && !h_waitrequest;
            @(negedge clk);
        end
        n_vec++;
        if (np != 5) begin
            n_err++;
            $display("FAIL b2b_count got %0d pulses expected 5", np);
        end
    endtask

    task automatic test_interleaved();
        bit          wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [21:0] ad [4] = '{22'h5, 22'h5, 22'h6, 22'h6};
        logic [31:0] wd [4] = '{32'hAAAA_5555, 32'h0, 32'h0F0F_0F0F, 32'h0};
        logic [31:0] er [2] = '{32'hAAAA_5555, 32'h0F0F_0F0F};
        int idx = 0;
        int np = 0;
        int nr = 0;
        bit acc = 1'b0;
        resp_delay = int'($urandom_range(1, RD_TO));
        for (int k = 0; k < 400 && nr < 2; k++) begin
            if (m_read || m_write) begin
                n_vec++;
                if (np >= 4 || m_write !== wr[np] || m_address !== ad[np]) begin
                    n_err++;
                    $display("FAIL interleaved_order n=%0d got wr=%b addr=%h", np, m_write, m_address);
                end
                np++;
            end
            if (h_readdatavalid) begin
                n_vec++;
                if (nr >= 2 || h_readdata !== er[nr] || h_rderror !== 1'b0) begin
                    n_err++;
                    $display("FAIL interleaved_read n=%0d got %h err=%b", nr, h_readdata, h_rderror);
                end
                nr++;
            end
            if (acc) begin idx++; h_read = 1'b0; h_write = 1'b0; end
            if (!h_read && !h_write && idx < 4) begin
                h_write = wr[idx]; h_read = !wr[idx]; h_address = ad[idx]; h_writedata = wd[idx];
            end
            acc = (h_read || h_write) && !h_waitrequest;
            @(negedge clk);
        end
        n_vec++;
        if (nr != 2 || np != 4) begin
            n_err++;
            $display("FAIL interleaved_count got reads=%0d pulses=%0d expected 2 and 4", nr, np);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        resp_delay = 0;
        for (int k = 0; k < 36; k++) begin
            if (k == 0) begin h_read = 1'b1; h_address = 22'h20; end
            if (k == 1) begin h_read = 1'b0; h_write = 1'b1; h_address = 22'h21; h_writedata = 32'h1357_9BDF; end
            if (k == 2) h_write = 1'b0;
            n_vec++;
            if (m_read !== 1'(k == 2) || m_write !== 1'(k == RD_TO + 6)) begin
                n_err++;
                $display("FAIL timeout_pulses k=%0d got rd=%b wr=%b expected rd=%b wr=%b", k, m_read, m_write, k == 2, k == RD_TO + 6);
            end
            n_vec++;
            if (h_readdatavalid !== 1'(k == RD_TO + 4) || h_rderror !== 1'(k == RD_TO + 4)) begin
                n_err++;
                $display("FAIL timeout_rdv k=%0d got rdv=%b err=%b expected %b", k, h_readdatavalid, h_rderror, k == RD_TO + 4);
            end
            if (k == RD_TO + 4) begin
                n_vec++;
                if (h_readdata !== 32'hDEAD_BEEF) begin
                    n_err++;
                    $display("FAIL timeout_data got %h expected deadbeef", h_readdata);
                end
            end
            if (k == RD_TO + 6) begin
                n_vec++;
                if (m_address !== 22'h21 || m_writedata !== 32'h1357_9BDF) begin
                    n_err++;
                    $display("FAIL timeout_next got addr=%h wd=%h expected 000021 13579bdf", m_address, m_writedata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_spurious_both();
        resp_delay = 3;
        spur = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (h_readdatavalid !== 1'b0 || m_read !== 1'b0 || m_write !== 1'b0) begin
                n_err++;
                $display("FAIL spurious_idle k=%0d got rdv=%b rd=%b wr=%b expected 0", k, h_readdatavalid, m_read, m_write);
            end
            @(negedge clk);
        end
        h_read = 1'b1; h_write = 1'b1; h_address = 22'h30; h_writedata = 32'hC0DE_F00D;
        for (int k = 0; k < WR_GAP + 12; k++) begin
            if (k == 1) begin h_read = 1'b0; h_write = 1'b0; end
            n_vec++;
            if (m_write !== 1'(k == 2) || m_read !== 1'b0 || h_readdatavalid !== 1'b0) begin
                n_err++;
                $display("FAIL both_req k=%0d got wr=%b rd=%b rdv=%b expected wr=%b rd=0 rdv=0", k, m_write, m_read, h_readdatavalid, k == 2);
            end
            if (k == 2) begin
                n_vec++;
                if (m_address !== 22'h30 || m_writedata !== 32'hC0DE_F00D) begin
                    n_err++;
                    $display("FAIL both_req_data got addr=%h wd=%h expected 000030 c0def00d", m_address, m_writedata);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        cmd_t exp_q [$];
        logic [31:0] rdexp_q [$];
        logic [31:0] ref_mem [logic [21:0]];
        cmd_t c;
        cmd_t cur = '0;
        bit have_cur = 1'b0;
        logic [31:0] e;
        int sent = 0;
        int low = 3;
        int r;
        bit pend = 1'b0;
        bit acc = 1'b0;
        resp_delay = int'($urandom_range(1, RD_TO));
        for (int k = 0; k < 5000 && (sent < 40 || pend || exp_q.size() > 0 || rdexp_q.size() > 0); k++) begin
            if (m_read || m_write) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL random_pulse k=%0d unexpected pulse rd=%b wr=%b addr=%h", k, m_read, m_write, m_address);
                end else begin
                    c = exp_q.pop_front();
                    if ({m_write, m_read, m_address, m_writedata} !== {c.wr, ~c.wr, c.a, c.d}) begin
                        n_err++;
                        $display("FAIL random_pulse k=%0d got wr=%b rd=%b addr=%h wd=%h expected wr=%b addr=%h wd=%h",
                                 k, m_write, m_read, m_address, m_writedata, c.wr, c.a, c.d);
                    end
                    cur = c;
                    have_cur = 1'b1;
                end
                n_vec++;
                if (low < 3) begin
                    n_err++;
                    $display("FAIL random_spacing k=%0d got %0d low cycles expected >=3", k, low);
                end
                low = 0;
            end else begin
                low++;
                if (have_cur) begin
                    n_vec++;
                    if (m_address !== cur.a || m_writedata !== cur.d) begin
                        n_err++;
                        $display("FAIL random_stable k=%0d got addr=%h wd=%h expected addr=%h wd=%h", k, m_address, m_writedata, cur.a, cur.d);
                    end
                end
            end
            if (h_readdatavalid) begin
                n_vec++;
                if (rdexp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL random_read k=%0d unexpected readdatavalid data=%h", k, h_readdata);
                end else begin
                    e = rdexp_q.pop_front();
                    if (h_readdata !== e || h_rderror !== 1'b0) begin
                        n_err++;
                        $display("FAIL random_read k=%0d got %h err=%b expected %h err=0", k, h_readdata, h_rderror, e);
                    end
                end
            end
            if (acc) begin pend = 1'b0; h_read = 1'b0; h_write = 1'b0; end
            if (!pend && sent < 40 && $urandom_range(0, 2) != 0) begin
                r = int'($urandom_range(0, 9));
                h_read = (r < 5) || (r == 9);
                h_write = (r >= 5);
                h_address = 22'(512 + $urandom_range(0, 7));
                h_writedata = $urandom;
                pend = 1'b1;
                sent++;
            end
            acc = pend && !h_waitrequest;
            if (acc) begin
                exp_q.push_back({h_write, h_address, h_writedata});
                if (h_write) ref_mem[h_address] = h_writedata;
                else rdexp_q.push_back(ref_mem.exists(h_address) ? ref_mem[h_address] : 32'h0);
            end
            @(negedge clk);
        end
        n_vec++;
        if (exp_q.size() != 0 || rdexp_q.size() != 0 || pend) begin
            n_err++;
            $display("FAIL random_drain got %0d pulses and %0d reads outstanding expected 0", exp_q.size(), rdexp_q.size());
        end
        h_read = 1'b0;
        h_write = 1'b0;
        repeat (WR_GAP + 8) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        resp_delay = 5;
        for (int k = 0; k < 40; k++) begin
            if (k < 4) begin
                n_vec++;
                if (h_waitrequest !== 1'b0 || m_read !== 1'(k == 2)) begin
                    n_err++;
                    $display("FAIL midrst_fill k=%0d got wait=%b rd=%b expected wait=0 rd=%b", k, h_waitrequest, m_read, k == 2);
                end
                h_read = 1'b1;
                h_address = 22'(768 + k);
            end
            if (k == 4) begin h_read = 1'b0; rst = 1'b1; end
            if (k == 5) begin
                n_vec++;
                if ({m_read, m_write, h_readdatavalid, h_rderror} !== 4'b0 || m_address !== '0 || m_writedata !== '0 || h_readdata !== '0 || h_waitrequest !== 1'b1) begin
                    n_err++;
                    $display("FAIL midrst_outputs got rd=%b wr=%b rdv=%b err=%b addr=%h wd=%h rdata=%h wait=%b expected 0s and wait=1",
                             m_read, m_write, h_readdatavalid, h_rderror, m_address, m_writedata, h_readdata, h_waitrequest);
                end
                rst = 1'b0;
            end
            if (k > 5) begin
                n_vec++;
                if (h_readdatavalid !== 1'b0 || m_read !== 1'b0 || m_write !== 1'b0 || h_waitrequest !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_flushed k=%0d got rdv=%b rd=%b wr=%b wait=%b expected 0", k, h_readdatavalid, m_read, m_write, h_waitrequest);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_interleaved();
        test_timeout();
        test_spurious_both();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
